// File: rtl/regbank16_16b_wr_pkg.sv
// Shared widths, FSM encoding and helpers for the 16x16 register bank.
package regbank16_16b_wr_pkg;

  localparam int unsigned W_DATA    = 16;
  localparam int unsigned W_ENTRIES = 16;
  localparam int unsigned W_SEL     = 4;
  localparam int unsigned W_LEN     = W_SEL + 1;
  localparam int unsigned W_TOTAL   = W_ENTRIES * W_DATA;

  // Largest burst the bank can take in one go: one pass over every entry.
  localparam logic [W_LEN-1:0] LEN_MAX = 5'd16;
  localparam logic [W_LEN-1:0] LEN_ONE = 5'd1;
  localparam logic [W_LEN-1:0] LEN_ZERO = 5'd0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Requests longer than the bank wrap onto already-written entries, so cap them.
  function automatic logic [W_LEN-1:0] clamp_len(input logic [W_LEN-1:0] len);
    logic [W_LEN-1:0] res;
    if (len > LEN_MAX) begin
      res = LEN_MAX;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/regbank16_16b_wr_if.sv
// Write/burst bus of the register bank; master drives requests, slave is the bank.
interface regbank16_16b_wr_if;
  import regbank16_16b_wr_pkg::*;

  logic               wr_en;
  logic [W_SEL-1:0]   wr_idx;
  logic [W_DATA-1:0]  wr_data;
  logic               burst_start;
  logic [W_SEL-1:0]   burst_base;
  logic [W_LEN-1:0]   burst_len;
  logic               burst_valid;
  logic [W_DATA-1:0]  burst_data;
  logic               burst_ready;
  logic               burst_done;
  logic               busy;

  modport master (
    output wr_en, wr_idx, wr_data,
    output burst_start, burst_base, burst_len, burst_valid, burst_data,
    input  burst_ready, burst_done, busy
  );

  modport slave (
    input  wr_en, wr_idx, wr_data,
    input  burst_start, burst_base, burst_len, burst_valid, burst_data,
    output burst_ready, burst_done, busy
  );

endinterface

// File: rtl/regbank16_16b_wr_dec4_16.sv
// 4-bit index plus enable to 16-bit one-hot write-enable decoder.
module dec4_16 (
  input  logic        en,
  input  logic [3:0]  idx,
  output logic [15:0] onehot
);

  // One-hot decode, all zero when not enabled.
  always_comb begin
    onehot = 16'h0000;
    if (en) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = 16'h0000;
    end
  end

endmodule

// File: rtl/regbank16_16b_wr.sv
// 16-entry x 16-bit register bank with single-word writes and a sequential burst fill.
module regbank16_16b_wr
  import regbank16_16b_wr_pkg::*;
#(
  parameter int wData    = 16,
  parameter int wEntries = 16,
  parameter int wSel     = 4,
  parameter int wTotal   = 256
) (
  input  logic                clk,
  input  logic                rst,
  regbank16_16b_wr_if.slave   bus,
  output logic [wTotal-1:0]   Out
);

  state_t             state;
  state_t             state_next;
  logic [wSel-1:0]    ptr;
  logic [wSel:0]      remaining;
  logic [wData-1:0]   entries [wEntries];
  logic               done_q;

  logic               beat_accept;
  logic               last_beat;
  logic               burst_arm;
  logic               dec_en;
  logic [wSel-1:0]    sel_idx;
  logic [wData-1:0]   sel_data;
  logic [15:0]        we_onehot;

  // Handshake qualifiers derived from the current state and inputs.
  always_comb begin
    beat_accept = 1'b0;
    burst_arm   = 1'b0;
    if (state == ST_BURST) begin
      beat_accept = bus.burst_valid;
    end else begin
      burst_arm = bus.burst_start && (bus.burst_len != LEN_ZERO);
    end
    last_beat = beat_accept && (remaining == LEN_ONE);
  end

  // Shared decoder input: single-write path in IDLE, burst pointer in BURST.
  always_comb begin
    sel_idx  = bus.wr_idx;
    sel_data = bus.wr_data;
    dec_en   = 1'b0;
    if (state == ST_BURST) begin
      sel_idx  = ptr;
      sel_data = bus.burst_data;
      dec_en   = beat_accept;
    end else begin
      sel_idx  = bus.wr_idx;
      sel_data = bus.wr_data;
      dec_en   = bus.wr_en;
    end
  end

  dec4_16 u_dec (
    .en     (dec_en),
    .idx    (sel_idx),
    .onehot (we_onehot)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (burst_arm) begin
          state_next = ST_BURST;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (last_beat) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_BURST;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: burst handshake is open only while in BURST.
  always_comb begin
    bus.burst_ready = 1'b0;
    bus.busy        = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.burst_ready = 1'b0;
        bus.busy        = 1'b0;
      end
      ST_BURST: begin
        bus.burst_ready = 1'b1;
        bus.busy        = 1'b1;
      end
      default: begin
        bus.burst_ready = 1'b0;
        bus.busy        = 1'b0;
      end
    endcase
  end

  // Burst pointer, beat counter and the registered completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= last_beat;
      if (burst_arm) begin
        ptr       <= bus.burst_base;
        remaining <= clamp_len(bus.burst_len);
      end else if (beat_accept) begin
        ptr       <= ptr + wSel'(1'b1);
        remaining <= remaining - (wSel + 1)'(1'b1);
      end else begin
        ptr       <= ptr;
        remaining <= remaining;
      end
    end
  end

  assign bus.burst_done = done_q;

  // Entry storage: one decoded entry per edge, all cleared on reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < wEntries; k++) begin
      if (rst) begin
        entries[k] <= '0;
      end else if (we_onehot[k]) begin
        entries[k] <= sel_data;
      end else begin
        entries[k] <= entries[k];
      end
    end
  end

  // Flatten the bank, entry 0 in the least significant bits.
  always_comb begin
    Out = '0;
    for (int k = 0; k < wEntries; k++) begin
      Out[k*wData +: wData] = entries[k];
    end
  end

endmodule

// File: tb/tb_regbank16_16b_wr.sv
// Directed self-checking bench for the register bank.
module tb_regbank16_16b_wr;
  import regbank16_16b_wr_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] Out;
  logic [15:0]  model [16];
  int           tests = 0;
  int           fails = 0;

  regbank16_16b_wr_if bus ();

  regbank16_16b_wr dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .Out (Out)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [255:0] flat();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k*16 +: 16] = model[k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_idx = 4'd0; bus.wr_data = 16'h0000;
    bus.burst_start = 1'b0; bus.burst_base = 4'd0; bus.burst_len = 5'd0;
    bus.burst_valid = 1'b0; bus.burst_data = 16'h0000;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) model[k] = 16'h0000;
    tests++; if (Out !== flat()) begin fails++; $display("FAIL reset_out got %h want %h", Out, flat()); end
    tests++; if (bus.burst_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", bus.burst_ready); end
    tests++; if (bus.burst_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.burst_done); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_single_write();
    logic [255:0] exp_v;
    bus.wr_en = 1'b1; bus.wr_idx = 4'd5; bus.wr_data = 16'hBEEF;
    tick();
    bus.wr_en = 1'b0;
    model[5] = 16'hBEEF;
    exp_v = 256'h0;
    exp_v[95:80] = 16'hBEEF;
    tests++; if (Out !== exp_v) begin fails++; $display("FAIL single_write got %h want %h", Out, exp_v); end
    bus.wr_en = 1'b1; bus.wr_idx = 4'd0; bus.wr_data = 16'h0F0F;
    tick();
    bus.wr_en = 1'b0;
    model[0] = 16'h0F0F;
    tests++; if (Out !== flat()) begin fails++; $display("FAIL single_write_e0 got %h want %h", Out, flat()); end
  endtask

  task automatic test_burst_wrap();
    logic [15:0] beats [4];
    beats[0] = 16'h1111; beats[1] = 16'h2222; beats[2] = 16'h3333; beats[3] = 16'h4444;
    bus.burst_start = 1'b1; bus.burst_base = 4'd14; bus.burst_len = 5'd4;
    tick();
    bus.burst_start = 1'b0;
    tests++; if (bus.busy !== 1'b1 || bus.burst_ready !== 1'b1) begin fails++; $display("FAIL wrap_armed got busy=%b ready=%b want 1 1", bus.busy, bus.burst_ready); end
    for (int b = 0; b < 4; b++) begin
      bus.burst_valid = 1'b1; bus.burst_data = beats[b];
      tick();
      if (b < 3) begin
        tests++; if (bus.burst_done !== 1'b0) begin fails++; $display("FAIL wrap_early_done beat %0d got %b want 0", b, bus.burst_done); end
      end
    end
    bus.burst_valid = 1'b0;
    model[14] = 16'h1111; model[15] = 16'h2222; model[0] = 16'h3333; model[1] = 16'h4444;
    tests++; if (bus.burst_done !== 1'b1) begin fails++; $display("FAIL wrap_done got %b want 1", bus.burst_done); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL wrap_busy got %b want 0", bus.busy); end
    tests++; if (Out !== flat()) begin fails++; $display("FAIL wrap_data got %h want %h", Out, flat()); end
    tick();
    tests++; if (bus.burst_done !== 1'b0) begin fails++; $display("FAIL wrap_done_pulse got %b want 0", bus.burst_done); end
  endtask

  task automatic test_stall();
    logic [15:0] beats [3];
    beats[0] = 16'h0A0A; beats[1] = 16'h0B0B; beats[2] = 16'h0C0C;
    bus.burst_start = 1'b1; bus.burst_base = 4'd2; bus.burst_len = 5'd3;
    tick();
    bus.burst_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.burst_valid = 1'b1; bus.burst_data = beats[b];
      tick();
      model[2 + b] = beats[b];
      if (b < 2) begin
        bus.burst_valid = 1'b0; bus.burst_data = 16'hDEAD;
        tick();
        tick();
        tests++; if (bus.burst_done !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL stall_state beat %0d got done=%b busy=%b want 0 1", b, bus.burst_done, bus.busy); end
        tests++; if (Out !== flat()) begin fails++; $display("FAIL stall_data beat %0d got %h want %h", b, Out, flat()); end
      end
    end
    bus.burst_valid = 1'b0;
    tests++; if (bus.burst_done !== 1'b1) begin fails++; $display("FAIL stall_done got %b want 1", bus.burst_done); end
    tests++; if (Out !== flat()) begin fails++; $display("FAIL stall_final got %h want %h", Out, flat()); end
    tick();
  endtask

  task automatic test_ignore_in_burst();
    bus.burst_start = 1'b1; bus.burst_base = 4'd8; bus.burst_len = 5'd2;
    tick();
    bus.burst_start = 1'b0;
    bus.burst_valid = 1'b1; bus.burst_data = 16'h5555;
    tick();
    model[8] = 16'h5555;
    bus.burst_valid = 1'b0;
    bus.wr_en = 1'b1; bus.wr_idx = 4'd7; bus.wr_data = 16'hAAAA;
    bus.burst_start = 1'b1; bus.burst_base = 4'd0; bus.burst_len = 5'd5;
    tick();
    idle_inputs();
    tests++; if (Out !== flat()) begin fails++; $display("FAIL ignore_wr got %h want %h", Out, flat()); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL ignore_busy got %b want 1", bus.busy); end
    bus.burst_valid = 1'b1; bus.burst_data = 16'h6666;
    tick();
    bus.burst_valid = 1'b0;
    model[9] = 16'h6666;
    tests++; if (bus.burst_done !== 1'b1) begin fails++; $display("FAIL ignore_done got %b want 1", bus.burst_done); end
    tests++; if (Out !== flat()) begin fails++; $display("FAIL ignore_ptr got %h want %h", Out, flat()); end
    tick();
  endtask

  task automatic test_len_zero();
    bus.burst_start = 1'b1; bus.burst_base = 4'd3; bus.burst_len = 5'd0;
    bus.burst_valid = 1'b1; bus.burst_data = 16'hFFFF;
    tick();
    bus.burst_start = 1'b0;
    tests++; if (bus.busy !== 1'b0 || bus.burst_ready !== 1'b0) begin fails++; $display("FAIL len0_state got busy=%b ready=%b want 0 0", bus.busy, bus.burst_ready); end
    tick();
    bus.burst_valid = 1'b0;
    tests++; if (bus.burst_done !== 1'b0) begin fails++; $display("FAIL len0_done got %b want 0", bus.burst_done); end
    tests++; if (Out !== flat()) begin fails++; $display("FAIL len0_data got %h want %h", Out, flat()); end
  endtask

  task automatic test_back_to_back();
    bus.wr_en = 1'b1; bus.wr_idx = 4'd3; bus.wr_data = 16'h1234;
    bus.burst_start = 1'b1; bus.burst_base = 4'd4; bus.burst_len = 5'd1;
    tick();
    idle_inputs();
    model[3] = 16'h1234;
    tests++; if (Out !== flat()) begin fails++; $display("FAIL same_cycle_wr got %h want %h", Out, flat()); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL same_cycle_busy got %b want 1", bus.busy); end
    bus.burst_valid = 1'b1; bus.burst_data = 16'h4321;
    tick();
    bus.burst_valid = 1'b0;
    model[4] = 16'h4321;
    tests++; if (bus.burst_done !== 1'b1 || Out !== flat()) begin fails++; $display("FAIL same_cycle_beat got done=%b out=%h want 1 %h", bus.burst_done, Out, flat()); end
    tick();
  endtask

  task automatic test_len_clamp();
    int  accepted;
    bit  done_seen;
    accepted = 0;
    done_seen = 1'b0;
    bus.burst_start = 1'b1; bus.burst_base = 4'd0; bus.burst_len = 5'd20;
    tick();
    bus.burst_start = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      bus.burst_valid = 1'b1; bus.burst_data = 16'h0100 + 16'(i);
      if (bus.burst_ready === 1'b1) accepted++;
      tick();
      if (bus.burst_done === 1'b1) done_seen = 1'b1;
    end
    bus.burst_valid = 1'b0;
    for (int k = 0; k < 16; k++) model[k] = 16'h0100 + 16'(k);
    tests++; if (!done_seen) begin fails++; $display("FAIL clamp_timeout got no done want done"); end
    tests++; if (accepted != 16) begin fails++; $display("FAIL clamp_beats got %0d want 16", accepted); end
    tests++; if (Out !== flat()) begin fails++; $display("FAIL clamp_data got %h want %h", Out, flat()); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bus.burst_start = 1'b1; bus.burst_base = 4'd0; bus.burst_len = 5'd4;
    tick();
    bus.burst_start = 1'b0;
    bus.burst_valid = 1'b1; bus.burst_data = 16'h0001;
    tick();
    bus.burst_data = 16'h0002;
    tick();
    bus.burst_data = 16'h9999;
    bus.wr_en = 1'b1; bus.wr_idx = 4'd6; bus.wr_data = 16'h7777;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 16; k++) model[k] = 16'h0000;
    tests++; if (Out !== flat()) begin fails++; $display("FAIL rst_mid_out got %h want %h", Out, flat()); end
    tests++; if (bus.busy !== 1'b0 || bus.burst_done !== 1'b0) begin fails++; $display("FAIL rst_mid_state got busy=%b done=%b want 0 0", bus.busy, bus.burst_done); end
    tick();
    tests++; if (bus.burst_done !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL rst_mid_after got done=%b busy=%b want 0 0", bus.burst_done, bus.busy); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_stall();
    test_ignore_in_burst();
    test_len_zero();
    test_back_to_back();
    test_len_clamp();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regbank16_16b_wr.md
REGBANK16_16B_WR -- requirements
Module: regbank16_16b_wr

Interface
REQ-001 Parameter wData, default 16, data width of each entry.
REQ-002 Parameter wEntries, default 16, number of entries.
REQ-003 Parameter wSel, default 4, index width.
REQ-004 Parameter wTotal, default 256, flattened bus width (wEntries*wData).
REQ-005 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  single-word write request.
REQ-009 wr_idx  input  wSel  target entry of single write.
REQ-010 wr_data  input  wData  single-write data.
REQ-011 burst_start  input  1  begin sequential fill.
REQ-012 burst_base  input  wSel  first entry of burst.
REQ-013 burst_len  input  wSel+1  beat count, 0..31.
REQ-014 burst_valid  input  1  burst beat present.
REQ-015 burst_data  input  wData  burst beat data.
REQ-016 burst_ready  output  1  high while a burst beat can be accepted.
REQ-017 burst_done  output  1  one-cycle completion pulse.
REQ-018 busy  output  1  high while in BURST state.
REQ-019 Out  output  wTotal  flattened entries; entry k occupies bits [16k+15:16k] (entry 0 in LSBs).

Function
REQ-020 Out SHALL be driven directly from the entry registers; a write at edge N is visible on Out after edge N, no other latency.
REQ-021 FSM states SHALL be IDLE and BURST only.
REQ-022 IDLE: wr_en=1 writes wr_data into entry wr_idx at the next edge; exactly one entry changes.
REQ-023 IDLE: burst_start=1 with burst_len in 1..16 latches base as pointer, len as remaining count, moves to BURST.
REQ-024 burst_len=0 SHALL be a no-op (stay IDLE, no burst_done); burst_len>16 SHALL be clamped to 16.
REQ-025 IDLE with wr_en and burst_start in the same cycle: single write performed and burst armed on the same edge.
REQ-026 BURST: burst_ready=1 and busy=1; a beat is accepted when burst_valid&burst_ready.
REQ-027 Accepted beat writes burst_data to entry at pointer, pointer increments modulo 16 (15 wraps to 0), remaining decrements.
REQ-028 burst_valid=0 in BURST SHALL stall with no state change.
REQ-029 Acceptance of the final beat returns FSM to IDLE on that edge and asserts burst_done for exactly the following cycle.
REQ-030 BURST: wr_en and burst_start SHALL be ignored (no write, no restart).
REQ-031 IDLE: burst_ready=0, busy=0; burst_valid ignored.

Reset
REQ-032 rst=1 at an edge SHALL clear all 16 entries to 0x0000, FSM to IDLE, pointer and count to 0.
REQ-033 After reset: Out=0, burst_ready=0, burst_done=0, busy=0.
REQ-034 rst mid-burst SHALL abort the burst with no burst_done and discard any beat presented that cycle.
REQ-035 rst SHALL take priority over every write request in the same cycle.

Structure
REQ-036 Widths (wData, wEntries, wSel, wTotal) and FSM state encodings SHALL live in the shared package/include for the register-bank blocks.
REQ-037 Write decode SHALL use one sub-module, dec4_16 (4-bit index plus enable to 16-bit one-hot write-enable).
REQ-038 Single-write and burst paths SHALL share that decoder via a 2:1 index/data select on FSM state.

Verification
REQ-039 Reset then wr_en, wr_idx=5, wr_data=0xBEEF -> next cycle Out[95:80]=0xBEEF, all other bits 0.
REQ-040 burst_start base=14 len=4, beats 0x1111,0x2222,0x3333,0x4444 -> entries 14,15,0,1 hold them; burst_done one cycle after the 4th beat; busy low.
REQ-041 Burst len=3 with burst_valid low 2 cycles between beats -> no extra writes, burst_done only after 3rd accepted beat.
REQ-042 During BURST, wr_en idx=7 data=0xAAAA and burst_start -> entry 7 unchanged, burst continues from original pointer.
REQ-043 burst_len=0 -> state stays IDLE, burst_done never asserts; burst_len=20 -> exactly 16 beats accepted.
REQ-044 rst after 2 beats of a len-4 burst -> all Out=0, busy=0, no burst_done.
